axi_rd_sched_bus0: RTL
======================

Name: axi_rd_sched_bus0

Overview:
- Round-robin scheduler for the bus0 AXI read path. It shares the single read address/data route between up to NMST masters.
- It grants one master at a time and holds the grant from the AR handshake until the final R beat (RLAST) completes, then rotates priority.
- It drives the read-side master/slave index selection consumed by the bus0 interconnect mux. It does not touch the write path.

Parameters:
- NMST, 4: number of requesting masters, 2..7.
- MST_LOG2, 3: width of the grant index. Must satisfy NMST < 2**MST_LOG2, so that NMST itself is encodable as the "no grant" value.
- TMO_CYCLES, 1023: watchdog limit in DATA state. Used only with the optional feature.

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  asynchronous active-low reset.
- i_req  in  NMST  per-master ARVALID.
- i_ar_ready  in  1  ARREADY from the addressed slave (already muxed).
- i_r_valid  in  1  RVALID from the active slave.
- i_r_last  in  1  RLAST from the active slave.
- i_r_ready  in  1  RREADY from the granted master (already muxed).
- o_gnt  out  NMST  one-hot grant; all zero when idle.
- o_gnt_idx  out  MST_LOG2  granted master index; NMST when idle.
- o_busy  out  1  high in ADDR or DATA.
- o_timeout  out  1  one-cycle pulse on watchdog abort (optional feature only; tied 0 otherwise).

Behaviour:
- Reset values (async on i_nrst low): state=IDLE, o_gnt=0, o_gnt_idx=NMST, o_busy=0, o_timeout=0, last_idx=NMST-1 (so master 0 wins first).
- All outputs are registered.

State machine:
- IDLE: if i_req!=0, select the first set bit searching upward from (last_idx+1) mod NMST, wrapping around. Register the selection into o_gnt/o_gnt_idx and go to ADDR. Grant is visible one cycle after the request is sampled.
- ADDR:
  - AR handshake is i_req[o_gnt_idx] & i_ar_ready. On handshake go to DATA.
  - If i_req[o_gnt_idx] deasserts before the handshake (protocol violation), return to IDLE. Clear the grant and leave last_idx unchanged.
- DATA:
  - Count beats; a beat is i_r_valid & i_r_ready.
  - On a beat with i_r_last=1: last_idx<=o_gnt_idx, clear the grant, go to IDLE.
  - Beats without RLAST stay in DATA.
  - Changes on i_req are ignored in this state.

Timing and fairness:
- There is always one IDLE bubble between transactions. Minimum turnaround from an RLAST beat to the next grant is 2 cycles.
- Only one outstanding read transaction system-wide; no ID interleaving.
- Fairness: a continuously requesting master waits at most NMST-1 transactions.
- Simultaneous requests in IDLE are resolved purely by the rotating pointer.
- i_ar_ready or i_r_valid arriving while in IDLE is ignored.
- Reset asserted mid-transaction returns to the reset values immediately. Partial bursts are not tracked.
- Index arithmetic: the pointer wraps modulo NMST, never modulo 2**MST_LOG2.

Optional Feature:
- Macro: AXI_RD_SCHED_TIMEOUT_EN.
- Defined:
  - A TMO counter, wide enough for TMO_CYCLES, clears on entry to DATA and on every beat, and increments on each DATA cycle without a beat.
  - When it reaches TMO_CYCLES: pulse o_timeout for 1 cycle, set last_idx<=o_gnt_idx, clear the grant, go to IDLE.
  - Counter reset value is 0.
- Undefined: no counter; o_timeout is constant 0; DATA waits indefinitely.

Decomposition:
- Package axi_rd_sched_bus0_pkg:
  - state enum (IDLE/ADDR/DATA);
  - registers struct (state, gnt, gnt_idx, last_idx, tmo_cnt);
  - reset constant for that struct.
- Sub-module rr_pick_bus0: combinational rotate-and-find-first. Inputs are the request vector and pointer; outputs are a found flag and the index. It is also reusable for the write scheduler.

Test Plan:
- Reset, then i_req=4'b0101 → cycle+1: o_gnt=0001, o_gnt_idx=0, o_busy=1. Complete a 1-beat burst → next grant goes to master 2 (o_gnt=0100) after a 1-cycle IDLE bubble.
- All four masters request continuously, each doing 4-beat bursts → grant order 0,1,2,3,0,…; each burst ends only on the RLAST beat.
- Master 1 drops i_req in ADDR before i_ar_ready → back to IDLE, o_gnt_idx=4. Next arbitration still starts searching from master 1.
- RLAST asserted with i_r_ready=0 for 3 cycles → grant held; released only on the cycle i_r_ready=1.
- i_nrst pulsed low in the middle of a DATA burst → o_gnt=0, o_gnt_idx=4, o_busy=0 asynchronously; master 0 wins first afterwards.
- With AXI_RD_SCHED_TIMEOUT_EN and TMO_CYCLES=8: no R beats after the AR handshake → o_timeout pulses exactly at the 8th idle DATA cycle, grant clears, next master is granted.

Source files
------------

// File: rtl/axi_rd_sched_bus0_pkg.sv
// Shared types for the bus0 AXI read scheduler: FSM state encoding,
// the scheduler register bundle and its reset value.
package axi_rd_sched_bus0_pkg;

  // Storage widths sized for the largest supported configuration (7 masters).
  localparam int GNT_W = 7;
  localparam int IDX_W = 3;
  localparam int TMO_W = 32;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    ADDR = S_ADDR,
    DATA = S_DATA
  } state_e;

  typedef struct packed {
    state_e             state;
    logic [GNT_W-1:0]   gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   last_idx;
    logic [TMO_W-1:0]   tmo_cnt;
  } regs_t;

  // Reset value: no grant (index == nmst) and pointer at nmst-1 so master 0 wins first.
  function automatic regs_t regs_rst(input int nmst);
    regs_t r;
    r.state    = IDLE;
    r.gnt      = '0;
    r.gnt_idx  = IDX_W'(nmst);
    r.last_idx = IDX_W'(nmst - 1);
    r.tmo_cnt  = '0;
    return r;
  endfunction

endpackage

// File: rtl/axi_rd_sched_bus0_rr_pick.sv
// rr_pick_bus0: combinational rotate-and-find-first. Searches req_i upward
// starting at (ptr_i+1) mod NMST, wrapping, and returns the first set index.
module rr_pick_bus0 #(
  parameter int NMST  = 4,
  parameter int IDX_W = 3
) (
  input  logic [NMST-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam int PAD_W = 1 << IDX_W;
  localparam int SUM_W = IDX_W + 1;

  logic [PAD_W-1:0] req_pad;
  logic [SUM_W-1:0] cand;

  assign req_pad = PAD_W'(req_i);

  // Walk candidates in rotated order; the pointer wraps modulo NMST.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= NMST; k++) begin
      cand = {1'b0, ptr_i} + SUM_W'(k);
      if (cand >= SUM_W'(NMST)) cand = cand - SUM_W'(NMST);
      if (!found_o && req_pad[cand[IDX_W-1:0]]) begin
        found_o = 1'b1;
        idx_o   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/axi_rd_sched_bus0.sv
// Round-robin scheduler for the bus0 AXI read path. One master owns the read
// route from grant through its RLAST beat; priority then rotates.
// Optional watchdog in DATA enabled by `define AXI_RD_SCHED_TIMEOUT_EN.
module axi_rd_sched_bus0
  import axi_rd_sched_bus0_pkg::*;
#(
  parameter int NMST       = 4,
  parameter int MST_LOG2   = 3,
  parameter int TMO_CYCLES = 1023
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic [NMST-1:0]     i_req,
  input  logic                i_ar_ready,
  input  logic                i_r_valid,
  input  logic                i_r_last,
  input  logic                i_r_ready,
  output logic [NMST-1:0]     o_gnt,
  output logic [MST_LOG2-1:0] o_gnt_idx,
  output logic                o_busy,
  output logic                o_timeout
);

  localparam int    PAD_W    = 1 << IDX_W;
  localparam regs_t REGS_RST = regs_rst(NMST);

  regs_t            r_q, r_d;
  logic             busy_q, busy_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [PAD_W-1:0] req_pad;
  logic             req_gnt;
  logic             beat;
  logic             tmo_fire;

  rr_pick_bus0 #(
    .NMST  (NMST),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (i_req),
    .ptr_i   (r_q.last_idx),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign req_pad = PAD_W'(i_req);
  assign req_gnt = req_pad[r_q.gnt_idx];
  assign beat    = i_r_valid & i_r_ready;

  // Next-state logic for the grant FSM and the DATA-phase watchdog.
  always_comb begin
    r_d      = r_q;
    tmo_fire = 1'b0;
    case (r_q.state)
      IDLE: begin
        if (pick_found) begin
          r_d.state   = ADDR;
          r_d.gnt     = GNT_W'(1) << pick_idx;
          r_d.gnt_idx = pick_idx;
        end
      end
      ADDR: begin
        // A master withdrawing ARVALID before the handshake forfeits the grant
        // without moving the pointer.
        if (!req_gnt) begin
          r_d.state   = IDLE;
          r_d.gnt     = '0;
          r_d.gnt_idx = IDX_W'(NMST);
        end else if (i_ar_ready) begin
          r_d.state   = DATA;
          r_d.tmo_cnt = '0;
        end
      end
      DATA: begin
        if (beat) begin
          r_d.tmo_cnt = '0;
          if (i_r_last) begin
            r_d.state    = IDLE;
            r_d.last_idx = r_q.gnt_idx;
            r_d.gnt      = '0;
            r_d.gnt_idx  = IDX_W'(NMST);
          end
        end
`ifdef AXI_RD_SCHED_TIMEOUT_EN
        else if (r_q.tmo_cnt == TMO_W'(TMO_CYCLES - 1)) begin
          // Stalled slave: abort the burst and rotate as if it completed.
          tmo_fire     = 1'b1;
          r_d.state    = IDLE;
          r_d.last_idx = r_q.gnt_idx;
          r_d.gnt      = '0;
          r_d.gnt_idx  = IDX_W'(NMST);
          r_d.tmo_cnt  = '0;
        end else begin
          r_d.tmo_cnt = r_q.tmo_cnt + TMO_W'(1);
        end
`endif
      end
      default: r_d = REGS_RST;
    endcase
    busy_d = (r_d.state != IDLE);
  end

  // Scheduler state registers with asynchronous reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_q    <= REGS_RST;
      busy_q <= 1'b0;
    end else begin
      r_q    <= r_d;
      busy_q <= busy_d;
    end
  end

`ifdef AXI_RD_SCHED_TIMEOUT_EN
  logic tmo_q;

  // One-cycle abort pulse, registered alongside the grant clear.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) tmo_q <= 1'b0;
    else         tmo_q <= tmo_fire;
  end

  assign o_timeout = tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = tmo_fire;
  assign o_timeout  = 1'b0;
`endif

  assign o_gnt     = r_q.gnt[NMST-1:0];
  assign o_gnt_idx = MST_LOG2'(r_q.gnt_idx);
  assign o_busy    = busy_q;

endmodule
